// File: rtl/wb_stage_pipe_pkg.sv
// Shared encodings for the writeback stage and its load-alignment helper.
//   wb_sel_e   : result source selected by the MEM stage
//   ld_size_e  : load access size
//   wb_state_e : writeback entry state
package wb_stage_pipe_pkg;

  typedef enum logic [1:0] {
    WB_SEL_EXEC = 2'b00,
    WB_SEL_LOAD = 2'b01,
    WB_SEL_LINK = 2'b10,
    WB_SEL_NONE = 2'b11
  } wb_sel_e;

  // Encoding 2'b11 is reserved and handled like a word load.
  typedef enum logic [1:0] {
    LD_BYTE = 2'b00,
    LD_HALF = 2'b01,
    LD_WORD = 2'b10
  } ld_size_e;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'b00,  // no entry held
    ST_WAIT_MEM = 2'b01,  // load held, response outstanding
    ST_COMMIT   = 2'b10,  // result known, written on the next edge
    ST_DRAIN    = 2'b11   // flushed load, swallowing its orphan response
  } wb_state_e;

endpackage

// File: rtl/wb_stage_pipe_load_align.sv
// Combinational load formatter: picks the addressed byte/half lane of a raw
// read word and sign- or zero-extends it to DATA_W. Word loads (and the
// reserved size) pass the raw word through unchanged, upper bits included.
// Ports:
//   rdata_i    [DATA_W-1:0] raw read word
//   size_i     [1:0]        access size (byte/half/word/reserved)
//   unsigned_i              zero-extend instead of sign-extend
//   off_i      [1:0]        byte offset within the low 32-bit word
//   data_o     [DATA_W-1:0] formatted result
module wb_load_align
  import wb_stage_pipe_pkg::*;
#(
  parameter int DATA_W = 32
) (
  input  logic [DATA_W-1:0] rdata_i,
  input  logic [1:0]        size_i,
  input  logic              unsigned_i,
  input  logic [1:0]        off_i,
  output logic [DATA_W-1:0] data_o
);

  logic [7:0]  byte_lane;
  logic [15:0] half_lane;
  logic        byte_fill;
  logic        half_fill;

  assign byte_lane = rdata_i[{off_i, 3'b000} +: 8];
  // off_i[0] is ignored for halves; misaligned halves never reach this stage.
  assign half_lane = rdata_i[{off_i[1], 4'b0000} +: 16];
  assign byte_fill = ~unsigned_i & byte_lane[7];
  assign half_fill = ~unsigned_i & half_lane[15];

  always_comb begin
    // NOTE: the default assignment ahead of the case keeps this block free of inferred latches.
    data_o = rdata_i;
    case (size_i)
      LD_BYTE: data_o = {{(DATA_W-8){byte_fill}}, byte_lane};
      LD_HALF: data_o = {{(DATA_W-16){half_fill}}, half_lane};
      default: data_o = rdata_i;
    endcase
  end

endmodule

// File: rtl/wb_stage_pipe.sv
// Registered writeback stage between MEM and the register file.
// Holds at most one retiring instruction, waits for load data when needed,
// formats sub-word loads, and writes the register file one edge after the
// result is known. A same-cycle bypass exposes the held result.
// Ports:
//   clk, rst                       clock, synchronous active-high reset
//   mm_valid / mm_ready            MEM handshake (transfer on both high)
//   mm_exec_out, mm_link           candidate results
//   mm_wb_sel, mm_rd               result select and destination
//   mm_ld_size/_unsigned/_off      load formatting controls
//   mem_rvalid, mem_rdata          data-memory read response
//   flush                          kill the held instruction
//   reg_wr_en/_addr/_data          registered register-file write port
//   byp_valid/_rd/_data            bypass view of the held entry
module wb_stage_pipe
  import wb_stage_pipe_pkg::*;
#(
  parameter int DATA_W      = 32,
  parameter int RADDR_W     = 5,
  parameter int ZERO_REG_EN = 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               mm_valid,
  output logic               mm_ready,
  input  logic [DATA_W-1:0]  mm_exec_out,
  input  logic [DATA_W-1:0]  mm_link,
  input  logic [1:0]         mm_wb_sel,
  input  logic [RADDR_W-1:0] mm_rd,
  input  logic [1:0]         mm_ld_size,
  input  logic               mm_ld_unsigned,
  input  logic [1:0]         mm_ld_off,
  input  logic               mem_rvalid,
  input  logic [DATA_W-1:0]  mem_rdata,
  input  logic               flush,
  output logic               reg_wr_en,
  output logic [RADDR_W-1:0] reg_wr_addr,
  output logic [DATA_W-1:0]  reg_wr_data,
  output logic               byp_valid,
  output logic [RADDR_W-1:0] byp_rd,
  output logic [DATA_W-1:0]  byp_data
);

  localparam bit ZeroRegEn = (ZERO_REG_EN != 0);

  wb_state_e          state_q;
  logic [RADDR_W-1:0] rd_q;
  logic [DATA_W-1:0]  data_q;
  logic               wen_q;      // entry targets the register file at all
  logic [1:0]         ld_size_q;
  logic               ld_uns_q;
  logic [1:0]         ld_off_q;
  logic               wr_en_q;
  logic [RADDR_W-1:0] wr_addr_q;
  logic [DATA_W-1:0]  wr_data_q;

  logic               accept;
  logic               write_ok;
  logic [DATA_W-1:0]  ld_fmt;

  wb_load_align #(.DATA_W(DATA_W)) u_align (
    .rdata_i    (mem_rdata),
    .size_i     (ld_size_q),
    .unsigned_i (ld_uns_q),
    .off_i      (ld_off_q),
    .data_o     (ld_fmt)
  );

  assign mm_ready = (state_q == ST_IDLE) || (state_q == ST_COMMIT);
  // Flush wins over a same-cycle transfer: ready is still shown, data dropped.
  assign accept   = mm_valid && mm_ready && !flush;
  assign write_ok = wen_q && !(ZeroRegEn && (rd_q == '0));

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      rd_q      <= '0;
      data_q    <= '0;
      wen_q     <= 1'b0;
      ld_size_q <= '0;
      ld_uns_q  <= 1'b0;
      ld_off_q  <= '0;
      wr_en_q   <= 1'b0;
      wr_addr_q <= '0;
      wr_data_q <= '0;
    end else begin
      // NOTE: non-blocking assignments throughout, so every branch sees the pre-edge state and later assignments in this block simply override earlier ones.
      wr_en_q <= 1'b0;

      case (state_q)
        ST_IDLE: state_q <= ST_IDLE;

        ST_WAIT_MEM: begin
          if (flush) begin
            // A response arriving with the flush is consumed and dropped.
            state_q <= mem_rvalid ? ST_IDLE : ST_DRAIN;
          end else if (mem_rvalid) begin
            data_q  <= ld_fmt;
            state_q <= ST_COMMIT;
          end
        end

        ST_COMMIT: begin
          // Address/data only move on a real write so they hold otherwise.
          if (write_ok && !flush) begin
            wr_en_q   <= 1'b1;
            wr_addr_q <= rd_q;
            wr_data_q <= data_q;
          end
          state_q <= ST_IDLE;
        end

        ST_DRAIN: begin
          if (mem_rvalid) state_q <= ST_IDLE;
        end

        default: state_q <= ST_IDLE;
      endcase

      // A new transfer (only possible in IDLE/COMMIT) overrides the
      // IDLE fall-through chosen above.
      if (accept) begin
        rd_q      <= mm_rd;
        wen_q     <= (mm_wb_sel != WB_SEL_NONE);
        data_q    <= (mm_wb_sel == WB_SEL_LINK) ? mm_link : mm_exec_out;
        ld_size_q <= mm_ld_size;
        ld_uns_q  <= mm_ld_unsigned;
        ld_off_q  <= mm_ld_off;
        state_q   <= (mm_wb_sel == WB_SEL_LOAD) ? ST_WAIT_MEM : ST_COMMIT;
      end
    end
  end

  assign reg_wr_en   = wr_en_q;
  assign reg_wr_addr = wr_addr_q;
  assign reg_wr_data = wr_data_q;

  assign byp_valid = (state_q == ST_COMMIT) && write_ok;
  assign byp_rd    = rd_q;
  assign byp_data  = data_q;

endmodule

// File: tb/tb_wb_stage_pipe.sv
// Directed bench for wb_stage_pipe with default parameters.
module tb_wb_stage_pipe;

  logic        clk = 1'b0;
  logic        rst;
  logic        mm_valid;
  logic        mm_ready;
  logic [31:0] mm_exec_out;
  logic [31:0] mm_link;
  logic [1:0]  mm_wb_sel;
  logic [4:0]  mm_rd;
  logic [1:0]  mm_ld_size;
  logic        mm_ld_unsigned;
  logic [1:0]  mm_ld_off;
  logic        mem_rvalid;
  logic [31:0] mem_rdata;
  logic        flush;
  logic        reg_wr_en;
  logic [4:0]  reg_wr_addr;
  logic [31:0] reg_wr_data;
  logic        byp_valid;
  logic [4:0]  byp_rd;
  logic [31:0] byp_data;

  int n_cmp = 0;
  int n_err = 0;

  wb_stage_pipe #(.DATA_W(32), .RADDR_W(5), .ZERO_REG_EN(1)) dut (
    .clk            (clk),
    .rst            (rst),
    .mm_valid       (mm_valid),
    .mm_ready       (mm_ready),
    .mm_exec_out    (mm_exec_out),
    .mm_link        (mm_link),
    .mm_wb_sel      (mm_wb_sel),
    .mm_rd          (mm_rd),
    .mm_ld_size     (mm_ld_size),
    .mm_ld_unsigned (mm_ld_unsigned),
    .mm_ld_off      (mm_ld_off),
    .mem_rvalid     (mem_rvalid),
    .mem_rdata      (mem_rdata),
    .flush          (flush),
    .reg_wr_en      (reg_wr_en),
    .reg_wr_addr    (reg_wr_addr),
    .reg_wr_data    (reg_wr_data),
    .byp_valid      (byp_valid),
    .byp_rd         (byp_rd),
    .byp_data       (byp_data)
  );

  always #5 clk = ~clk;

  // Outputs are sampled 1ns after the rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp)
    else begin
      n_err++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic drive_idle();
    mm_valid       = 1'b0;
    mm_exec_out    = '0;
    mm_link        = '0;
    mm_wb_sel      = 2'b00;
    mm_rd          = '0;
    mm_ld_size     = 2'b00;
    mm_ld_unsigned = 1'b0;
    mm_ld_off      = 2'b00;
    mem_rvalid     = 1'b0;
    mem_rdata      = '0;
    flush          = 1'b0;
  endtask

  task automatic drive_exec(input logic [1:0] sel, input logic [4:0] rd,
                            input logic [31:0] exec_v, input logic [31:0] link_v);
    mm_valid    = 1'b1;
    mm_wb_sel   = sel;
    mm_rd       = rd;
    mm_exec_out = exec_v;
    mm_link     = link_v;
  endtask

  // Load with the response one cycle after accept; checks the resulting write.
  task automatic do_load(input string tag, input logic [4:0] rd, input logic [1:0] size,
                         input logic uns, input logic [1:0] off,
                         input logic [31:0] rdata, input logic [31:0] exp);
    mm_valid = 1'b1; mm_wb_sel = 2'b01; mm_rd = rd;
    mm_ld_size = size; mm_ld_unsigned = uns; mm_ld_off = off;
    tick();
    mm_valid = 1'b0;
    check({tag, "_ready_wait"}, mm_ready, 1'b0);
    mem_rvalid = 1'b1; mem_rdata = rdata;
    tick();
    mem_rvalid = 1'b0; mem_rdata = 32'hA5A5_A5A5;
    check({tag, "_byp"}, byp_data, exp);
    check({tag, "_ready_commit"}, mm_ready, 1'b1);
    tick();
    check({tag, "_wr_en"}, reg_wr_en, 1'b1);
    check({tag, "_wr_addr"}, reg_wr_addr, rd);
    check({tag, "_wr_data"}, reg_wr_data, exp);
  endtask

  initial begin
    #20000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    drive_idle();
    rst = 1'b1;
    tick(); tick();
    rst = 1'b0;

    // Reset state
    check("rst_ready", mm_ready, 1'b1);
    check("rst_wr_en", reg_wr_en, 1'b0);
    check("rst_wr_addr", reg_wr_addr, 32'd0);
    check("rst_wr_data", reg_wr_data, 32'd0);
    check("rst_byp_valid", byp_valid, 1'b0);

    // Back-to-back exec then link
    drive_exec(2'b00, 5'd3, 32'h11, 32'hBAD0);
    tick();
    check("b2b_ready1", mm_ready, 1'b1);
    check("b2b_byp_valid1", byp_valid, 1'b1);
    check("b2b_byp_rd1", byp_rd, 32'd3);
    check("b2b_byp_data1", byp_data, 32'h11);
    check("b2b_wr_en0", reg_wr_en, 1'b0);
    drive_exec(2'b10, 5'd31, 32'hDEAD, 32'h400);
    tick();
    check("b2b_wr_en1", reg_wr_en, 1'b1);
    check("b2b_wr_addr1", reg_wr_addr, 32'd3);
    check("b2b_wr_data1", reg_wr_data, 32'h11);
    check("b2b_ready2", mm_ready, 1'b1);
    check("b2b_byp_data2", byp_data, 32'h400);
    mm_valid = 1'b0;
    tick();
    check("b2b_wr_en2", reg_wr_en, 1'b1);
    check("b2b_wr_addr2", reg_wr_addr, 32'd31);
    check("b2b_wr_data2", reg_wr_data, 32'h400);
    tick();
    check("b2b_wr_en_off", reg_wr_en, 1'b0);
    check("b2b_hold_addr", reg_wr_addr, 32'd31);
    check("b2b_hold_data", reg_wr_data, 32'h400);
    check("b2b_byp_off", byp_valid, 1'b0);

    // Sub-word and word loads, response one cycle after accept
    do_load("lb_s",   5'd5, 2'b00, 1'b0, 2'd2, 32'h0080_FF00, 32'hFFFF_FF80);
    do_load("lbu",    5'd6, 2'b00, 1'b1, 2'd2, 32'h0080_FF00, 32'h0000_0080);
    do_load("lb_o1",  5'd8, 2'b00, 1'b0, 2'd1, 32'h0000_7F00, 32'h0000_007F);
    do_load("lb_o3",  5'd8, 2'b00, 1'b0, 2'd3, 32'hC300_0000, 32'hFFFF_FFC3);
    do_load("lhu_o0", 5'd9, 2'b01, 1'b1, 2'd0, 32'hFFFF_8001, 32'h0000_8001);
    do_load("lh_o1",  5'd9, 2'b01, 1'b0, 2'd1, 32'h1234_8001, 32'hFFFF_8001);
    do_load("lw",     5'd4, 2'b10, 1'b0, 2'd0, 32'hCAFE_F00D, 32'hCAFE_F00D);
    do_load("lrsvd",  5'd4, 2'b11, 1'b0, 2'd3, 32'h8765_4321, 32'h8765_4321);

    // lh off=2 with the response three cycles after accept
    mm_valid = 1'b1; mm_wb_sel = 2'b01; mm_rd = 5'd7;
    mm_ld_size = 2'b01; mm_ld_unsigned = 1'b0; mm_ld_off = 2'd2;
    tick();
    mm_valid = 1'b0;
    check("lh3_ready_t0", mm_ready, 1'b0);
    tick();
    check("lh3_ready_t1", mm_ready, 1'b0);
    check("lh3_wr_en_t1", reg_wr_en, 1'b0);
    tick();
    check("lh3_ready_t2", mm_ready, 1'b0);
    mem_rvalid = 1'b1; mem_rdata = 32'h8001_1234;
    tick();
    mem_rvalid = 1'b0;
    check("lh3_wr_en_t3", reg_wr_en, 1'b0);
    tick();
    check("lh3_wr_en_t4", reg_wr_en, 1'b1);
    check("lh3_wr_addr", reg_wr_addr, 32'd7);
    check("lh3_wr_data", reg_wr_data, 32'hFFFF_8001);

    // Writes to x0 and no-write instructions are suppressed
    drive_exec(2'b00, 5'd0, 32'h55, 32'h0);
    tick();
    mm_valid = 1'b0;
    check("x0_byp_valid", byp_valid, 1'b0);
    tick();
    check("x0_wr_en", reg_wr_en, 1'b0);
    check("x0_hold_data", reg_wr_data, 32'hFFFF_8001);
    drive_exec(2'b11, 5'd9, 32'h77, 32'h0);
    tick();
    mm_valid = 1'b0;
    check("none_byp_valid", byp_valid, 1'b0);
    tick();
    check("none_wr_en", reg_wr_en, 1'b0);
    check("none_hold_addr", reg_wr_addr, 32'd7);

    // Flush in WAIT_MEM, orphan response two cycles later
    mm_valid = 1'b1; mm_wb_sel = 2'b01; mm_rd = 5'd10;
    mm_ld_size = 2'b10; mm_ld_unsigned = 1'b0; mm_ld_off = 2'd0;
    tick();
    mm_valid = 1'b0;
    flush = 1'b1;
    tick();
    flush = 1'b0;
    check("drain_ready1", mm_ready, 1'b0);
    tick();
    check("drain_ready2", mm_ready, 1'b0);
    mem_rvalid = 1'b1; mem_rdata = 32'h1234_5678;
    tick();
    mem_rvalid = 1'b0;
    check("drain_idle_ready", mm_ready, 1'b1);
    check("drain_byp_valid", byp_valid, 1'b0);
    check("drain_wr_en0", reg_wr_en, 1'b0);
    drive_exec(2'b00, 5'd12, 32'hABC, 32'h0);
    tick();
    mm_valid = 1'b0;
    check("drain_wr_en1", reg_wr_en, 1'b0);
    tick();
    check("post_drain_wr_en", reg_wr_en, 1'b1);
    check("post_drain_wr_addr", reg_wr_addr, 32'd12);
    check("post_drain_wr_data", reg_wr_data, 32'hABC);

    // Flush in COMMIT kills the write and discards a same-cycle transfer
    drive_exec(2'b00, 5'd14, 32'h5, 32'h0);
    tick();
    drive_exec(2'b00, 5'd15, 32'h6, 32'h0);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    mm_valid = 1'b0;
    check("cflush_wr_en", reg_wr_en, 1'b0);
    check("cflush_byp_valid", byp_valid, 1'b0);
    tick();
    check("cflush_wr_en2", reg_wr_en, 1'b0);
    check("cflush_hold_addr", reg_wr_addr, 32'd12);

    // Reset while in COMMIT
    drive_exec(2'b00, 5'd13, 32'h99, 32'h0);
    tick();
    mm_valid = 1'b0;
    check("rstc_byp_valid_pre", byp_valid, 1'b1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("rstc_wr_en", reg_wr_en, 1'b0);
    check("rstc_wr_addr", reg_wr_addr, 32'd0);
    check("rstc_wr_data", reg_wr_data, 32'd0);
    check("rstc_byp_valid", byp_valid, 1'b0);
    check("rstc_ready", mm_ready, 1'b1);
    tick();
    check("rstc_wr_en2", reg_wr_en, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/wb_stage_pipe.md
Name: wb_stage_pipe

Overview:
- Parametrised, registered successor to the combinational writeback mux. It sits between the MEM stage and the register file.
- Accepts one retiring instruction per cycle over a valid/ready handshake. Selects among ALU result, load data and link address, and formats sub-word loads with sign/zero extension.
- Waits for multi-cycle data-memory responses and back-pressures MEM while waiting.
- Drives a registered register-file write port and a same-cycle bypass port for the forwarding unit.

Parameters:
- DATA_W, 32, datapath width; must be a multiple of 8 and at least 32.
- RADDR_W, 5, register address width.
- ZERO_REG_EN, 1, when 1 a write to register 0 is suppressed (reg_wr_en stays 0).

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  synchronous active-high reset.
- mm_valid  in  1  MEM stage presents an instruction.
- mm_ready  out  1  WB can accept; transfer occurs when mm_valid & mm_ready.
- mm_exec_out  in  DATA_W  ALU/exec result.
- mm_link  in  DATA_W  return address (pc+4) for jal/jalr.
- mm_wb_sel  in  2  00 exec, 01 load, 10 link, 11 no write (store/branch).
- mm_rd  in  RADDR_W  destination register.
- mm_ld_size  in  2  00 byte, 01 half, 10 word, 11 reserved (treated as word).
- mm_ld_unsigned  in  1  zero-extend sub-word load.
- mm_ld_off  in  2  byte offset, address[1:0].
- mem_rvalid  in  1  data-memory read response valid.
- mem_rdata  in  DATA_W  raw read word.
- flush  in  1  kill the held instruction.
- reg_wr_en  out  1  register-file write enable, registered.
- reg_wr_addr  out  RADDR_W  registered.
- reg_wr_data  out  DATA_W  registered.
- byp_valid  out  1  a held entry's result is known (state COMMIT).
- byp_rd  out  RADDR_W  destination of the held entry.
- byp_data  out  DATA_W  formatted result of the held entry.

Behaviour:
- Reset: state IDLE, mm_ready=1, reg_wr_en=0, reg_wr_addr=0, reg_wr_data=0, byp_valid=0, all entry registers 0.
- States:
  - IDLE: no entry held.
  - WAIT_MEM: load held, data not yet returned.
  - COMMIT: result held, written next edge.
  - DRAIN: flushed load, awaiting its orphan response.
- mm_ready = (state==IDLE) | (state==COMMIT). It is low in WAIT_MEM and DRAIN.
- Accept (mm_valid & mm_ready):
  - wb_sel 01 -> WAIT_MEM.
  - Otherwise -> COMMIT, with data = exec or link per wb_sel. For wb_sel 11, reg_wr_en is forced to 0 on commit.
- WAIT_MEM:
  - mem_rvalid: format mem_rdata into the entry data -> COMMIT.
  - rvalid is ignored in IDLE/COMMIT; it is only valid after a load is accepted (never in the accept cycle).
- COMMIT, on each edge:
  - reg_wr_en <= write-enabled & !(ZERO_REG_EN & rd==0) & !flush; reg_wr_addr/data <= entry.
  - If a new accept happens in the same cycle -> next state per the accept rule; else -> IDLE.
- reg_wr_en is high exactly one cycle per committed entry. When it is 0, addr/data hold their last values.
- Latency:
  - Non-load accepted at edge T -> reg_wr_en high after edge T+1.
  - Load accepted at T, rvalid sampled at T+k (k≥1) -> write after edge T+k+1.
  - Throughput is 1 per cycle for non-loads.
- Load formatting:
  - byte: lane = rdata[8*off +: 8].
  - half: lane = rdata[16*off[1] +: 16]; off[0] is ignored, and misalignment is trapped upstream.
  - word (and reserved 11): full rdata.
  - Sign-extend byte/half to DATA_W unless ld_unsigned, in which case zero-extend.
  - Bits above 32 for word loads come from rdata unchanged.
- flush (priority over accept in the same cycle; mm_ready is still reported but the transfer is discarded):
  - IDLE -> IDLE.
  - COMMIT -> IDLE with no write.
  - WAIT_MEM without rvalid -> DRAIN.
  - WAIT_MEM with rvalid the same cycle -> IDLE (response consumed and dropped).
  - DRAIN: ignores flush. On mem_rvalid -> IDLE, data discarded, no write.
- Bypass: byp_valid=1 only in COMMIT with the entry write-enabled and rd≠0 (when ZERO_REG_EN). byp_rd/byp_data are combinational from the entry registers.
- Reset mid-load: a return to IDLE is permitted. The data-memory interface is reset by the same rst, so no orphan response follows.

Decomposition:
- Shared package holds:
  - WB_SEL_EXEC/LOAD/LINK/NONE encodings.
  - LD_BYTE/HALF/WORD encodings.
  - State encoding IDLE/WAIT_MEM/COMMIT/DRAIN.
- One sub-module is natural: wb_load_align. It is purely combinational (rdata, size, unsigned, off -> formatted data) and parametrised by DATA_W, so it can be reused by a future load-store unit.

Test Plan:
- Back-to-back non-loads: exec 0x11 rd3, then link 0x400 rd31 on consecutive cycles -> writes (3,0x11) and (31,0x400) on consecutive cycles, mm_ready constantly 1.
- lb with off=2, rdata=0x0080FF00, signed -> 0xFFFFFF80 written; the same with ld_unsigned -> 0x00000080; mm_ready low from accept until rvalid.
- lh off=2, rdata=0x8001_1234, signed, rvalid 3 cycles after accept -> write 0xFFFF8001 four cycles after accept.
- rd=0 exec write with ZERO_REG_EN=1 -> reg_wr_en stays 0 and byp_valid=0; with wb_sel=11 -> no write.
- flush in WAIT_MEM, rvalid 2 cycles later -> state DRAIN, mm_ready low until rvalid, no write, then IDLE and a next exec instruction accepted normally.
- rst asserted in COMMIT -> no write on the following edge; all outputs return to reset values.
